bubble_host_reader: RTL

BUBBLE_HOST_READER -- requirements
Module: bubble_host_reader

---
 rtl/bubble_host_reader.sv | 188 ++++++++++++++++++
 1 files changed

// File: rtl/bubble_host_reader.sv
// Bubble memory host-side page reader: sequences the drive controls toward the emulator
// core and packs the four data lines, one nibble per bit slot, into bytes of a page.
`timescale 1ns/1ps
module bubble_host_reader #(
    parameter int unsigned BITDIV = 120,
    parameter int unsigned BSSLEN = 4,
    parameter int unsigned LAT    = 8,
    parameter int unsigned SLOTS  = 128
) (
    input  logic       MCLK,
    input  logic       RESET,
    input  logic       START,
    input  logic       BOOT,
    input  logic       ABORT,
    output logic       nBSS,
    output logic       nBSEN,
    output logic       nREPEN,
    output logic       nBOOTEN,
    output logic       nSWAPEN,
    input  logic       DOUT0,
    input  logic       DOUT1,
    input  logic       DOUT2,
    input  logic       DOUT3,
    output logic [7:0] BYTE,
    output logic [6:0] BYTEADDR,
    output logic       nBYTEWR,
    output logic       BUSY,
    output logic       DONE
);

    localparam int unsigned CntW  = (BITDIV > 1) ? $clog2(BITDIV) : 1;
    localparam int unsigned SlotW = $clog2(BSSLEN + LAT + SLOTS + 1);

    localparam logic [CntW-1:0]  CntLast  = CntW'(BITDIV - 1);
    localparam logic [CntW-1:0]  CntMid   = CntW'(BITDIV / 2);
    localparam logic [SlotW-1:0] StepLast = SlotW'(BSSLEN - 1);
    localparam logic [SlotW-1:0] EnLast   = SlotW'(LAT - 1);
    localparam logic [SlotW-1:0] CapLast  = SlotW'(SLOTS - 1);

    typedef enum logic [2:0] {
        StIdle,
        StStep,
        StEnable,
        StCapture,
        StRelease,
        StFinish
    } state_e;

    state_e           state_q;
    logic [CntW-1:0]  cnt_q;
    logic [SlotW-1:0] slot_q;
    logic [3:0]       dout_q;
    logic [3:0]       lo_q;
    logic [7:0]       byte_q;
    logic [6:0]       addr_q;
    logic             nbss_q;
    logic             nbsen_q;
    logic             nbooten_q;
    logic             nbytewr_q;
    logic             busy_q;
    logic             done_q;

    logic slot_end;
    logic sample_pt;

    assign slot_end  = (cnt_q == CntLast);
    assign sample_pt = (cnt_q == CntMid);

    always_ff @(posedge MCLK or posedge RESET) begin
        if (RESET) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            slot_q    <= '0;
            dout_q    <= '0;
            lo_q      <= '0;
            byte_q    <= '0;
            addr_q    <= '0;
            nbss_q    <= 1'b1;
            nbsen_q   <= 1'b1;
            nbooten_q <= 1'b1;
            nbytewr_q <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            // Data lines pass through one register; the mid-slot sample sees this skew.
            dout_q    <= {DOUT3, DOUT2, DOUT1, DOUT0};
            nbytewr_q <= 1'b1;
            done_q    <= 1'b0;
            cnt_q     <= slot_end ? '0 : cnt_q + 1'b1;

            if (state_q != StIdle && ABORT) begin
                state_q   <= StIdle;
                cnt_q     <= '0;
                slot_q    <= '0;
                nbss_q    <= 1'b1;
                nbsen_q   <= 1'b1;
                nbooten_q <= 1'b1;
                busy_q    <= 1'b0;
            end else begin
                unique case (state_q)
                    StIdle: begin
                        cnt_q  <= '0;
                        slot_q <= '0;
                        if (START && !ABORT) begin
                            state_q   <= StStep;
                            nbss_q    <= 1'b0;
                            nbooten_q <= ~BOOT;
                            busy_q    <= 1'b1;
                        end
                    end
                    StStep: begin
                        if (slot_end) begin
                            if (slot_q == StepLast) begin
                                state_q <= StEnable;
                                slot_q  <= '0;
                                nbsen_q <= 1'b0;
                            end else begin
                                slot_q <= slot_q + 1'b1;
                            end
                        end
                    end
                    StEnable: begin
                        if (slot_end) begin
                            if (slot_q == EnLast) begin
                                state_q <= StCapture;
                                slot_q  <= '0;
                            end else begin
                                slot_q <= slot_q + 1'b1;
                            end
                        end
                    end
                    StCapture: begin
                        // Even slot holds the low nibble; odd slot completes and strobes the byte.
                        if (sample_pt) begin
                            if (slot_q[0]) begin
                                byte_q    <= {dout_q, lo_q};
                                addr_q    <= 7'(slot_q >> 1);
                                nbytewr_q <= 1'b0;
                            end else begin
                                lo_q <= dout_q;
                            end
                        end
                        if (slot_end) begin
                            if (slot_q == CapLast) begin
                                state_q <= StRelease;
                                slot_q  <= '0;
                                nbsen_q <= 1'b1;
                            end else begin
                                slot_q <= slot_q + 1'b1;
                            end
                        end
                    end
                    StRelease: begin
                        if (slot_end) begin
                            state_q   <= StFinish;
                            nbss_q    <= 1'b1;
                            nbooten_q <= 1'b1;
                            done_q    <= 1'b1;
                        end
                    end
                    StFinish: begin
                        state_q <= StIdle;
                        cnt_q   <= '0;
                        busy_q  <= 1'b0;
                    end
                    default: begin
                        state_q <= StIdle;
                        cnt_q   <= '0;
                        slot_q  <= '0;
                        busy_q  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign nBSS     = nbss_q;
    assign nBSEN    = nbsen_q;
    assign nBOOTEN  = nbooten_q;
    assign nREPEN   = 1'b1;
    assign nSWAPEN  = 1'b1;
    assign BYTE     = byte_q;
    assign BYTEADDR = addr_q;
    assign nBYTEWR  = nbytewr_q;
    assign BUSY     = busy_q;
    assign DONE     = done_q;

endmodule
